delay_multitap: RTL and testbench

Parametrised multi-repeat delay (echo) effect for the guitar audio path. It stores incoming samples in an internal circular buffer and sums up to NUM_TAPS delayed copies onto the dry sample. Repeat k is taken at k*delay_time samples back, and each successive repeat has a decaying gain. It sits between the codec sample source and the output mixer and is driven by a per-sample valid strobe.

---
 rtl/delay_pkg.sv | 36 +++
 rtl/delay_ram.sv | 24 ++
 rtl/delay_multitap.sv | 155 +++++++++++++++
 tb/tb_delay_multitap.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared widths, FSM states and arithmetic helpers for the multi-tap delay.
package delay_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_ADDR_W    = 12;
   localparam int DEF_NUM_TAPS  = 4;
   localparam int DEF_GAIN_W    = 5;
   localparam int DEF_GAIN_FRAC = 5;

   // IDLE accepts a sample, TAP issues reads / MACs, DRAIN finishes the last MAC,
   // SAT is the cycle in which the result is presented.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TAP   = 2'd1,
      DRAIN = 2'd2,
      SAT   = 2'd3
   } state_e;

   // Accumulator must hold the dry sample plus NUM_TAPS gained repeats.
   function automatic int acc_w(input int data_w, input int gain_w, input int num_taps);
      return data_w + gain_w + $clog2(num_taps + 1);
   endfunction

   // Clamp a wide signed value to the signed range of data_w bits.
   function automatic logic signed [63:0] sat_to_data_w(input logic signed [63:0] a,
                                                        input int data_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (a > hi) return hi;
      else if (a < lo) return lo;
      return a;
   endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: one write port, registered one-cycle read.
module delay_ram
   import delay_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
)(
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic signed [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0]        rd_addr_i,
   output logic signed [DATA_W-1:0] rd_data_o
);

   logic signed [DATA_W-1:0] mem_q [2**ADDR_W];

   // Write port and registered read port; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/delay_multitap.sv
// Multi-repeat echo: y(n) = x(n) + sum_k (x(n-kD) * g(k)) >>> GAIN_FRAC, saturated.
// Handshake: in_valid is a one-cycle strobe accepted only in IDLE; anything else
// is dropped and flags the sticky overrun. out_valid is a one-cycle strobe that
// qualifies out_sample, NUM_TAPS+2 cycles after acceptance.
module delay_multitap
   import delay_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int NUM_TAPS  = DEF_NUM_TAPS,
   parameter int GAIN_W    = DEF_GAIN_W,
   parameter int GAIN_FRAC = DEF_GAIN_FRAC
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   input  logic signed [DATA_W-1:0]          in_sample,
   input  logic                              bypass,
   input  logic [GAIN_W-1:0]                 delay_gain,
   input  logic [ADDR_W-1:0]                 delay_time,
   input  logic [$clog2(NUM_TAPS+1)-1:0]     delay_repeat,
   output logic                              out_valid,
   output logic signed [DATA_W-1:0]          out_sample,
   output logic                              busy,
   output logic                              overrun
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int R_W    = $clog2(NUM_TAPS + 1);
   localparam int DIST_W = ADDR_W + R_W;
   localparam int ACC_W  = acc_w(DATA_W, GAIN_W, NUM_TAPS);
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam logic [DIST_W-1:0] DEPTH_D = DIST_W'(DEPTH);
   localparam logic [R_W-1:0]    LAST_K  = R_W'(NUM_TAPS);

   state_e                    state_q;
   logic [ADDR_W-1:0]         wr_ptr_q;
   logic [ADDR_W:0]           fill_cnt_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [DATA_W-1:0]  x_q;
   logic                      bypass_q;
   logic [GAIN_W-1:0]         gain_q;
   logic [GAIN_W-1:0]         tap_gain_q;
   logic [ADDR_W-1:0]         d_q;
   logic [R_W-1:0]            rep_q;
   logic [R_W-1:0]            k_q;
   logic [DIST_W-1:0]         dist_q;
   logic                      tap_en_q;
   logic                      out_valid_q;
   logic signed [DATA_W-1:0]  out_sample_q;
   logic                      overrun_q;

   logic                      wr_en;
   logic [ADDR_W-1:0]         rd_addr;
   logic signed [DATA_W-1:0]  rd_data;
   logic                      tap_ok_d;
   logic signed [PROD_W-1:0]  prod_d;
   logic signed [PROD_W-1:0]  term_d;
   logic signed [ACC_W-1:0]   acc_d;
   logic signed [DATA_W-1:0]  sat_d;

   delay_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (in_sample),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   // Read address, tap qualification for tap k, and the MAC of the previous tap.
   always_comb begin
      wr_en    = (state_q == IDLE) && in_valid;
      rd_addr  = wr_ptr_q - dist_q[ADDR_W-1:0];
      tap_ok_d = (k_q <= rep_q) && (d_q != '0) && (dist_q < DEPTH_D) &&
                 (dist_q <= DIST_W'(fill_cnt_q));
      prod_d   = PROD_W'(rd_data) * PROD_W'($signed({1'b0, tap_gain_q}));
      term_d   = prod_d >>> GAIN_FRAC;
      acc_d    = tap_en_q ? (acc_q + ACC_W'(term_d)) : acc_q;
      sat_d    = DATA_W'(sat_to_data_w(64'(acc_d), DATA_W));
   end

   // Sequencer: accept, walk the taps with the read overlapped with the MAC,
   // present the saturated result, then advance the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         fill_cnt_q   <= '0;
         acc_q        <= '0;
         x_q          <= '0;
         bypass_q     <= 1'b0;
         gain_q       <= '0;
         tap_gain_q   <= '0;
         d_q          <= '0;
         rep_q        <= '0;
         k_q          <= '0;
         dist_q       <= '0;
         tap_en_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (in_valid && (state_q != IDLE)) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  acc_q    <= ACC_W'(in_sample);
                  x_q      <= in_sample;
                  bypass_q <= bypass;
                  gain_q   <= delay_gain;
                  d_q      <= delay_time;
                  rep_q    <= delay_repeat;
                  k_q      <= R_W'(1);
                  dist_q   <= DIST_W'(delay_time);
                  tap_en_q <= 1'b0;
                  state_q  <= TAP;
               end
            end
            TAP: begin
               acc_q      <= acc_d;
               tap_en_q   <= tap_ok_d;
               tap_gain_q <= gain_q;
               gain_q     <= gain_q - (gain_q >> 2);
               dist_q     <= dist_q + DIST_W'(d_q);
               if (k_q == LAST_K) state_q <= DRAIN;
               else               k_q     <= k_q + R_W'(1);
            end
            DRAIN: begin
               acc_q        <= acc_d;
               tap_en_q     <= 1'b0;
               out_valid_q  <= 1'b1;
               out_sample_q <= bypass_q ? x_q : sat_d;
               state_q      <= SAT;
            end
            SAT: begin
               wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
               if (!fill_cnt_q[ADDR_W]) fill_cnt_q <= fill_cnt_q + (ADDR_W+1)'(1);
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out_sample = out_sample_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_delay_multitap.sv
// Directed bench for delay_multitap: vector table plus multi-cycle corner cases.
module tb_delay_multitap;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 12;
   localparam int NUM_TAPS = 4;
   localparam int GAIN_W   = 5;
   localparam int R_W      = $clog2(NUM_TAPS + 1);
   localparam int LAT      = NUM_TAPS + 2;
   localparam int DEPTH    = 2**ADDR_W;

   typedef struct {
      logic signed [DATA_W-1:0] x;
      logic                     byp;
      logic [GAIN_W-1:0]        g;
      logic [ADDR_W-1:0]        d;
      logic [R_W-1:0]           r;
      logic signed [DATA_W-1:0] exp_y;
   } vec_t;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     in_valid = 1'b0;
   logic signed [DATA_W-1:0] in_sample = '0;
   logic                     bypass = 1'b0;
   logic [GAIN_W-1:0]        delay_gain = '0;
   logic [ADDR_W-1:0]        delay_time = '0;
   logic [R_W-1:0]           delay_repeat = '0;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_sample;
   logic                     busy;
   logic                     overrun;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   delay_multitap #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_TAPS (NUM_TAPS),
      .GAIN_W   (GAIN_W),
      .GAIN_FRAC(5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_sample    (in_sample),
      .bypass       (bypass),
      .delay_gain   (delay_gain),
      .delay_time   (delay_time),
      .delay_repeat (delay_repeat),
      .out_valid    (out_valid),
      .out_sample   (out_sample),
      .busy         (busy),
      .overrun      (overrun)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Strobe one sample, scramble the controls after acceptance, wait for the result.
   task automatic send(input vec_t v, output logic signed [DATA_W-1:0] y, output int lat);
      in_sample    = v.x;
      bypass       = v.byp;
      delay_gain   = v.g;
      delay_time   = v.d;
      delay_repeat = v.r;
      in_valid     = 1'b1;
      @(posedge clk); #1;
      in_valid     = 1'b0;
      in_sample    = ~v.x;
      bypass       = ~v.byp;
      delay_gain   = ~v.g;
      delay_time   = ~v.d;
      delay_repeat = ~v.r;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      y = out_sample;
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input string name, input vec_t v, input logic chk_lat);
      logic signed [DATA_W-1:0] y;
      int lat;
      send(v, y, lat);
      check({name, " y"}, y, v.exp_y);
      if (chk_lat) check({name, " latency"}, lat, LAT);
   endtask

   function automatic vec_t mk(input int x, input logic byp, input int g, input int d,
                               input int r, input int exp_y);
      vec_t v;
      v.x = DATA_W'(x);
      v.byp = byp;
      v.g = GAIN_W'(g);
      v.d = ADDR_W'(d);
      v.r = R_W'(r);
      v.exp_y = DATA_W'(exp_y);
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic signed [DATA_W-1:0] y;
      int lat;

      // Impulse: gain 0.5, D=10, R=2 -> echoes at 10 and 20 (g2=12)
      for (int n = 0; n < 25; n++)
         vecs.push_back(mk((n == 0) ? 16384 : 0, 1'b0, 16, 10, 2,
                           (n == 0) ? 16384 : (n == 10) ? 8192 : (n == 20) ? 6144 : 0));
      // D=0 contributes nothing
      vecs.push_back(mk(1000, 1'b0, 16, 0, 4, 1000));
      // R=0 ignores the previous sample one step back
      vecs.push_back(mk(500, 1'b0, 16, 1, 0, 500));
      // R=1, D=1 picks up the 500 just stored
      vecs.push_back(mk(0, 1'b0, 16, 1, 1, 250));

      // reset state
      @(posedge clk); #1;
      check("reset out_valid", out_valid, 0);
      check("reset out_sample", out_sample, 0);
      check("reset busy", busy, 0);
      check("reset overrun", overrun, 0);
      do_reset();

      for (int i = 0; i < vecs.size(); i++)
         run_vec($sformatf("table[%0d]", i), vecs[i], 1'b1);

      // Warm-up: taps beyond fill count are masked
      do_reset();
      for (int n = 0; n < 150; n++)
         run_vec($sformatf("warmup n=%0d", n), mk(1000, 1'b0, 16, 100, 4,
                 (n < 100) ? 1000 : 1500), 1'b0);

      // Saturation, positive then negative
      do_reset();
      for (int n = 0; n < 8; n++)
         run_vec($sformatf("sat_pos n=%0d", n), mk(30000, 1'b0, 31, 1, 4,
                 (n == 0) ? 30000 : 32767), 1'b0);
      do_reset();
      for (int n = 0; n < 8; n++)
         run_vec($sformatf("sat_neg n=%0d", n), mk(-30000, 1'b0, 31, 1, 4,
                 (n == 0) ? -30000 : -32768), 1'b0);

      // Bypass: same latency, sample still stored for later echoes
      do_reset();
      run_vec("bypass", mk(-1234, 1'b1, 16, 3, 1, -1234), 1'b1);
      run_vec("bypass echo n=1", mk(0, 1'b0, 16, 3, 1, 0), 1'b0);
      run_vec("bypass echo n=2", mk(0, 1'b0, 16, 3, 1, 0), 1'b0);
      run_vec("bypass echo n=3", mk(0, 1'b0, 16, 3, 1, -617), 1'b1);

      // Overrun: second strobe two cycles after the first is dropped
      do_reset();
      in_sample = 16'sd100; bypass = 1'b0; delay_gain = 5'd16;
      delay_time = 12'd5; delay_repeat = 3'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("busy after accept", busy, 1);
      @(posedge clk); #1;
      in_valid = 1'b1; in_sample = 16'sd200;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("overrun set", overrun, 1);
      cnt = 0; y = '0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin cnt++; y = out_sample; end
         @(posedge clk); #1;
      end
      check("overrun out_valid count", cnt, 1);
      check("overrun y", y, 100);
      check("overrun sticky", overrun, 1);
      do_reset();
      check("overrun cleared", overrun, 0);

      // Strobe during the SAT cycle is dropped too
      in_sample = 16'sd300; delay_gain = 5'd16; delay_time = 12'd5; delay_repeat = 3'd1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      check("sat-cycle first latency", lat, LAT);
      in_valid = 1'b1; in_sample = 16'sd400;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("sat-cycle overrun", overrun, 1);
      check("sat-cycle not accepted", busy, 0);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) cnt++;
         @(posedge clk); #1;
      end
      check("sat-cycle out_valid count", cnt, 0);

      // Reset in TAP aborts the sample in flight
      do_reset();
      run_vec("pre-abort", mk(777, 1'b0, 16, 5, 1, 777), 1'b0);
      in_sample = 16'sd555; in_valid = 1'b1;
      @(posedge clk); #1;
      in_sample = 16'sd556;
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort out_valid", out_valid, 0);
      check("abort out_sample", out_sample, 0);
      check("abort busy", busy, 0);
      check("abort overrun", overrun, 0);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) cnt++;
         @(posedge clk); #1;
      end
      check("abort out_valid count", cnt, 0);

      // Wrap: impulse at n=4092 echoes at n=4100 across wr_ptr wrap
      do_reset();
      for (int n = 0; n < DEPTH + 5; n++)
         run_vec($sformatf("wrap n=%0d", n), mk((n == 4092) ? 16384 : 0, 1'b0, 16, 8, 1,
                 (n == 4092) ? 16384 : (n == 4100) ? 8192 : 0), 1'b0);
      // Tap 2 at 2*D == DEPTH would alias onto the current sample; it must be masked
      run_vec("kD equals DEPTH", mk(1000, 1'b0, 16, 2048, 2, 1000), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
